tone_decoder: RTL
=================

// Module: tone_decoder
// PURPOSE
//  Listening end of the musical-box speaker line.
//  - Samples a 1-bit square-wave tone from the speaker pin (asynchronous to clk) and measures its period in clk cycles.
//  - Classifies the period against a 12-note octave-4 table and reports a debounced note index.
//  - Used on-board for loop-back self-check of the tone generator, and in benches as the speaker checker.
// PARAMETERS
//  CNT_W      17      period/timeout counter width
//  TIMEOUT    120000  cycles with no rising edge -> silence (10 ms @ 12 MHz)
//  TOL_SHIFT  6       match tolerance: |p - ref| <= ref >> TOL_SHIFT (~1.56 %)
//  STABLE_N   3       consecutive equal classifications needed to update the output
// PORTS
//  clk          in   1      system clock, 12 MHz
//  rst          in   1      asynchronous reset, active-high
//  speaker_in   in   1      tone square wave, asynchronous
//  note         out  4      0=C4 .. 11=B4; 0 while silent
//  note_valid   out  1      1 = stable recognised tone present
//  note_change  out  1      1-cycle pulse when note_valid rises or note changes while valid
//  period       out  CNT_W  last measured full period in cycles (rising edge to rising edge)
// BEHAVIOUR
//  Reset: all outputs 0; state SILENT; counter 0; stability count 0. Applies immediately, also mid-scan.
//  Input path:
//   - 2-FF synchroniser, then rising-edge detect: 2-cycle latency, pin to rise_pulse.
//  Counter:
//   - Cleared on every rise_pulse; otherwise increments.
//   - Saturates at TIMEOUT; never wraps.
//  FSM states:
//   - SILENT: rise_pulse -> ARMED. No measurement is made on the first edge.
//   - ARMED: rise_pulse -> latch period = counter + 1, go to SCAN with idx = 0.
//     Counter reaching TIMEOUT -> SILENT.
//   - SCAN: one table entry compared per cycle, idx 0..11, for 12 cycles.
//     First hit records hit_idx; no hit after idx 11 records MISS. Then go to ARMED.
//     A rise_pulse during SCAN still clears the counter, but its period is discarded.
//     SCAN is never aborted, except by reset.
//   - Timeout, from any state except SCAN: note = 0, note_valid = 0, stability count cleared.
//     note_change does not pulse. Go to SILENT.
//  Debounce (on SCAN exit):
//   - Result equal to candidate -> count++ (saturates at STABLE_N). Otherwise candidate = result, count = 1.
//   - Count reaching STABLE_N with candidate = hit:
//     - note = hit_idx, note_valid = 1.
//     - note_change pulses if note_valid was 0 or note differs.
//   - Count reaching STABLE_N with candidate = MISS: note_valid = 0, note = 0, no pulse.
//  Arithmetic: compare in CNT_W bits, unsigned. The absolute difference is computed as a mux of two subtractions (no sign bit).
//  Output latency: last counted edge + 2 (sync) + 1 (latch) + 12 (scan) + 1 (register) = 16 cycles.
//  Simultaneous events: a counter reaching TIMEOUT and a rise_pulse in the same cycle -> the edge wins.
//  Period range: periods < 16 cycles are outside spec. The output is undefined but must not hang the FSM.
// STRUCTURE
//  Package tone_decoder_pkg:
//   - NUM_NOTES = 12; state enum {SILENT, ARMED, SCAN}.
//   - NOTE_PERIOD[0:11] @ 12 MHz: 45866 43293 40864 38569 36404 34361 32433 30612 28895 27273 25742 24297.
//     Shared with the tone generator.
//  Sub-module speaker_edge_sync: 2-FF synchroniser + rise_pulse, reset to 0.
//  Top: counter, FSM, scan comparator, debounce, output registers.
// TESTING
//  12 MHz clk. Speaker stimulus drives ideal square waves, toggled on real time, not clk-aligned.
//  1. 440 Hz tone from reset
//     -> note_valid = 0 until the 4th rising edge.
//     -> note = 9 and note_valid = 1 exactly 16 cycles later, one note_change pulse; period within 27273 +/- 2.
//  2. 261.63 Hz (5 periods), then 493.88 Hz
//     -> note 0, then note 11 after the 3rd B4 period.
//     -> exactly two note_change pulses in total.
//  3. Stop toggling while A4 is valid
//     -> note_valid = 0 and note = 0 exactly TIMEOUT + 2 cycles after the last rising edge; no pulse.
//     -> restart at 440 Hz re-acquires note 9.
//  4. 300 Hz tone (40000 cycles, between D4 and D#4, outside tolerance)
//     -> never valid; after a valid E4, 3 periods of 300 Hz clear note_valid.
//  5. A4 with one glitched period (20000 cycles) inserted -> note stays 9, no note_change.
//  6. Assert rst during SCAN -> all outputs 0 immediately; next tone needs arm + 3 periods again.

Source files
------------

// File: rtl/tone_decoder_pkg.sv
// tone_decoder_pkg
// Shared definitions for the speaker-line tone decoder.
//   NUM_NOTES    number of entries in the octave-4 note table
//   NOTE_W       width of a note index
//   PERIOD_W     width of a note-table period entry
//   stateT       decoder FSM states
//   periodT      one note-table period entry
//   NOTE_PERIOD  full periods of C4..B4 in 12 MHz clock cycles; the tone
//                generator uses the same table, so both ends agree
package tone_decoder_pkg;

  localparam int NUM_NOTES = 12;
  localparam int NOTE_W    = 4;
  localparam int PERIOD_W  = 17;

  typedef enum logic [1:0] {
    SILENT,
    ARMED,
    SCAN
  } stateT;

  typedef logic [PERIOD_W-1:0] periodT;

  localparam periodT NOTE_PERIOD [NUM_NOTES] = '{
    17'd45866, 17'd43293, 17'd40864, 17'd38569,
    17'd36404, 17'd34361, 17'd32433, 17'd30612,
    17'd28895, 17'd27273, 17'd25742, 17'd24297
  };

endpackage

// File: rtl/speaker_edge_sync.sv
// speaker_edge_sync
// Brings the asynchronous speaker pin into the clk domain and flags its
// rising edges.
//   clk         system clock
//   rst         asynchronous reset, active-high
//   speaker_in  raw speaker square wave, asynchronous to clk
//   rise_pulse  one-cycle pulse, two cycles after the pin rises
module speaker_edge_sync
  import tone_decoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic speaker_in,
  output logic rise_pulse
);

  logic syncMeta;
  logic syncOut;
  logic syncPrev;

  // Two flops to settle metastability, then a third copy one cycle older so
  // the rising edge can be seen as "now high, previously low".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncMeta <= 1'b0;
      syncOut  <= 1'b0;
      syncPrev <= 1'b0;
    end else begin
      syncMeta <= speaker_in;
      syncOut  <= syncMeta;
      syncPrev <= syncOut;
    end
  end

  assign rise_pulse = syncOut & ~syncPrev;

endmodule

// File: rtl/tone_decoder.sv
// tone_decoder
// Measures the period of the speaker square wave, matches it against the
// octave-4 note table one entry per cycle, and reports a debounced note.
//   clk          system clock, 12 MHz
//   rst          asynchronous reset, active-high
//   speaker_in   tone square wave, asynchronous
//   note         0=C4 .. 11=B4; 0 while silent
//   note_valid   a stable recognised tone is present
//   note_change  one-cycle pulse when note_valid rises or the note changes
//   period       last measured full period in cycles
module tone_decoder
  import tone_decoder_pkg::*;
#(
  parameter int     CNT_W     = 17,
  parameter int     TIMEOUT   = 120000,
  parameter int     TOL_SHIFT = 6,
  parameter int     STABLE_N  = 3,
  parameter periodT NOTE_TABLE [NUM_NOTES] = NOTE_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              speaker_in,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              note_change,
  output logic [CNT_W-1:0]  period
);

  localparam int STB_W = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [NOTE_W-1:0] LAST_IDX  = NOTE_W'(NUM_NOTES - 1);
  localparam logic [STB_W-1:0]  STB_MAX   = STB_W'(STABLE_N);
  localparam logic [STB_W-1:0]  STB_ONE   = STB_W'(1);

  logic              risePulse;
  logic [CNT_W-1:0]  counter;
  stateT             state;
  stateT             nextState;
  logic              latchPeriod;
  logic              timeoutHit;
  logic              clearOnTimeout;
  logic              scanLast;

  logic [NOTE_W-1:0] scanIdx;
  logic              scanHit;
  logic [NOTE_W-1:0] hitIdx;
  logic [CNT_W-1:0]  refPeriod;
  logic [CNT_W-1:0]  absDiff;
  logic              entryHit;

  logic              resultReady;
  logic              resultHit;
  logic [NOTE_W-1:0] resultIdx;
  logic              candHit;
  logic [NOTE_W-1:0] candIdx;
  logic [STB_W-1:0]  stableCount;
  logic              sameResult;
  logic [STB_W-1:0]  nextCount;

  speaker_edge_sync edgeSync (
    .clk        (clk),
    .rst        (rst),
    .speaker_in (speaker_in),
    .rise_pulse (risePulse)
  );

  // Cycles since the last rising edge. Saturating rather than wrapping keeps
  // a silent line parked at the timeout value instead of aliasing into a
  // plausible-looking period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
    end else if (risePulse) begin
      counter <= '0;
    end else if (counter != TIMEOUT_C) begin
      counter <= counter + 1'b1;
    end
  end

  // An edge in the same cycle as the timeout wins, so the timeout only counts
  // when there is no rise. SCAN ignores it; the scan finishes into ARMED and
  // the saturated counter then times out from there.
  assign timeoutHit     = (counter == TIMEOUT_C) && !risePulse;
  assign clearOnTimeout = timeoutHit && (state != SCAN);
  assign scanLast       = (state == SCAN) && (scanIdx == LAST_IDX);

  // State register for the SILENT -> ARMED -> SCAN loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SILENT;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. The first edge after silence only arms the decoder,
  // because there is no earlier edge to measure from. Edges arriving during
  // a scan are not measured; the counter still restarts on them.
  always_comb begin
    nextState   = state;
    latchPeriod = 1'b0;
    case (state)
      SILENT: begin
        if (risePulse) begin
          nextState = ARMED;
        end
      end
      ARMED: begin
        if (risePulse) begin
          nextState   = SCAN;
          latchPeriod = 1'b1;
        end else if (timeoutHit) begin
          nextState = SILENT;
        end
      end
      SCAN: begin
        if (scanLast) begin
          nextState = ARMED;
        end
      end
      default: begin
        nextState = SILENT;
      end
    endcase
  end

  // Tolerance test for the table entry under scan. The absolute difference
  // picks whichever subtraction cannot underflow, so everything stays
  // unsigned in CNT_W bits.
  always_comb begin
    refPeriod = CNT_W'(NOTE_TABLE[scanIdx]);
    if (period >= refPeriod) begin
      absDiff = period - refPeriod;
    end else begin
      absDiff = refPeriod - period;
    end
    entryHit = (absDiff <= (refPeriod >> TOL_SHIFT));
  end

  // Period latch and the twelve-cycle table walk. The first matching entry
  // is kept; the finished result is handed to the debouncer one cycle after
  // the last compare. A miss is recorded with index 0 so that any two misses
  // compare equal in the debouncer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period      <= '0;
      scanIdx     <= '0;
      scanHit     <= 1'b0;
      hitIdx      <= '0;
      resultReady <= 1'b0;
      resultHit   <= 1'b0;
      resultIdx   <= '0;
    end else begin
      resultReady <= 1'b0;
      if (latchPeriod) begin
        period  <= counter + 1'b1;
        scanIdx <= '0;
        scanHit <= 1'b0;
        hitIdx  <= '0;
      end else if (state == SCAN) begin
        if (entryHit && !scanHit) begin
          scanHit <= 1'b1;
          hitIdx  <= scanIdx;
        end
        if (scanLast) begin
          resultReady <= 1'b1;
          resultHit   <= scanHit || entryHit;
          if (scanHit) begin
            resultIdx <= hitIdx;
          end else if (entryHit) begin
            resultIdx <= scanIdx;
          end else begin
            resultIdx <= '0;
          end
        end else begin
          scanIdx <= scanIdx + 1'b1;
        end
      end
    end
  end

  // Repeat-count bookkeeping for the debouncer: a result that matches the
  // current candidate extends its run, anything else starts a new run of one.
  always_comb begin
    sameResult = (resultHit == candHit) && (resultIdx == candIdx);
    nextCount  = STB_ONE;
    if (sameResult) begin
      if (stableCount == STB_MAX) begin
        nextCount = STB_MAX;
      end else begin
        nextCount = stableCount + 1'b1;
      end
    end
  end

  // Debouncer and output registers. The outputs only move once a result has
  // been seen STABLE_N times in a row, so a single glitched period never
  // disturbs a valid note. A timeout silences the outputs without a pulse
  // and takes priority over a result landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candHit     <= 1'b0;
      candIdx     <= '0;
      stableCount <= '0;
      note        <= '0;
      note_valid  <= 1'b0;
      note_change <= 1'b0;
    end else begin
      note_change <= 1'b0;
      if (resultReady) begin
        candHit     <= resultHit;
        candIdx     <= resultIdx;
        stableCount <= nextCount;
        if (nextCount == STB_MAX) begin
          if (resultHit) begin
            note       <= resultIdx;
            note_valid <= 1'b1;
            if (!note_valid || (note != resultIdx)) begin
              note_change <= 1'b1;
            end
          end else begin
            note       <= '0;
            note_valid <= 1'b0;
          end
        end
      end
      if (clearOnTimeout) begin
        note        <= '0;
        note_valid  <= 1'b0;
        note_change <= 1'b0;
        stableCount <= '0;
      end
    end
  end

endmodule
